// File: rtl/cpu_defs.sv
// Shared CPU definitions: exception flag bit positions, ExcCode values, vector address.
package cpu_defs;

   localparam int unsigned EXC_W  = 8;
   localparam int unsigned CODE_W = 5;

   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

   // Bit positions inside ex_exc
   localparam int unsigned EXC_INT     = 0;
   localparam int unsigned EXC_ADEL_IF = 1;
   localparam int unsigned EXC_RI      = 2;
   localparam int unsigned EXC_OV      = 3;
   localparam int unsigned EXC_SYS     = 4;
   localparam int unsigned EXC_BP      = 5;
   localparam int unsigned EXC_ADEL    = 6;
   localparam int unsigned EXC_ADES    = 7;

   // CP0 Cause.ExcCode values
   localparam logic [CODE_W-1:0] CODE_INT  = 5'd0;
   localparam logic [CODE_W-1:0] CODE_ADEL = 5'd4;
   localparam logic [CODE_W-1:0] CODE_ADES = 5'd5;
   localparam logic [CODE_W-1:0] CODE_SYS  = 5'd8;
   localparam logic [CODE_W-1:0] CODE_BP   = 5'd9;
   localparam logic [CODE_W-1:0] CODE_RI   = 5'd10;
   localparam logic [CODE_W-1:0] CODE_OV   = 5'd12;

   // Source of the BadVAddr value for address-error exceptions
   typedef enum logic [1:0] {
      BADV_NONE  = 2'd0,
      BADV_PC    = 2'd1,
      BADV_DADDR = 2'd2
   } badv_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational exception priority encoder: picks the highest-priority flag.
module exc_prio_enc
   import cpu_defs::*;
(
   input  logic [EXC_W-1:0]  i_flags,
   output logic              o_valid,
   output logic [CODE_W-1:0] o_code,
   output badv_sel_e         o_badv_sel
);

   // Fixed priority: INT > ADEL_IF > RI > OV > SYS > BP > ADEL > ADES
   always_comb begin
      o_valid    = 1'b1;
      o_code     = CODE_INT;
      o_badv_sel = BADV_NONE;
      if (i_flags[EXC_INT]) begin
         o_code = CODE_INT;
      end else if (i_flags[EXC_ADEL_IF]) begin
         o_code     = CODE_ADEL;
         o_badv_sel = BADV_PC;
      end else if (i_flags[EXC_RI]) begin
         o_code = CODE_RI;
      end else if (i_flags[EXC_OV]) begin
         o_code = CODE_OV;
      end else if (i_flags[EXC_SYS]) begin
         o_code = CODE_SYS;
      end else if (i_flags[EXC_BP]) begin
         o_code = CODE_BP;
      end else if (i_flags[EXC_ADEL]) begin
         o_code     = CODE_ADEL;
         o_badv_sel = BADV_DADDR;
      end else if (i_flags[EXC_ADES]) begin
         o_code     = CODE_ADES;
         o_badv_sel = BADV_DADDR;
      end else begin
         o_valid = 1'b0;
      end
   end

endmodule

// File: rtl/exc_sequencer.sv
// Exception entry / ERET sequencer: CP0 strobes, pipeline flush and held PC redirect.
module exc_sequencer
   import cpu_defs::*;
#(
   parameter int unsigned      PC_W       = 32,
   parameter logic [PC_W-1:0]  EXC_VECTOR = PC_W'(EXC_VECTOR_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic              ex_in_ds,
   input  logic [EXC_W-1:0]  ex_exc,
   input  logic              ex_eret,
   input  logic [PC_W-1:0]   ex_daddr,
   input  logic              int_pending,
   input  logic              cp0_exl,
   input  logic [PC_W-1:0]   cp0_epc,
   input  logic              fetch_ready,
   output logic              stall,
   output logic              flush,
   output logic              redirect,
   output logic [PC_W-1:0]   redirect_pc,
   output logic              cp0_exc_we,
   output logic [CODE_W-1:0] cp0_exccode,
   output logic              cp0_epc_we,
   output logic [PC_W-1:0]   cp0_epc_o,
   output logic              cp0_bd,
   output logic              cp0_badv_we,
   output logic [PC_W-1:0]   cp0_badv,
   output logic              cp0_eret_we
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COMMIT   = 2'd1,
      S_REDIRECT = 2'd2
   } state_e;

   state_e            r_state, w_state_nxt;
   logic              r_stall, r_flush, r_redirect;
   logic              r_exc_we, r_epc_we, r_badv_we, r_eret_we;
   logic              w_stall_nxt, w_flush_nxt, w_redirect_nxt;
   logic              w_exc_we_nxt, w_epc_we_nxt, w_badv_we_nxt, w_eret_we_nxt;
   logic [CODE_W-1:0] r_code;
   logic [PC_W-1:0]   r_epc, r_badv, r_target;
   logic              r_bd;

   logic [EXC_W-1:0]  w_flags;
   logic              w_exc_valid;
   logic [CODE_W-1:0] w_exc_code;
   badv_sel_e         w_badv_sel;
   logic              w_take_exc, w_take_eret, w_latch;

   // A pending interrupt from CP0 is folded into the INT flag
   assign w_flags = ex_exc | EXC_W'(int_pending);

   exc_prio_enc u_prio (
      .i_flags    (w_flags),
      .o_valid    (w_exc_valid),
      .o_code     (w_exc_code),
      .o_badv_sel (w_badv_sel)
   );

   assign w_take_exc  = ex_valid & w_exc_valid;
   assign w_take_eret = ex_valid & ex_eret & ~w_exc_valid;
   assign w_latch     = (r_state == S_IDLE) & (w_take_exc | w_take_eret);

   // Next state and next registered control outputs
   always_comb begin
      w_state_nxt    = r_state;
      w_stall_nxt    = 1'b0;
      w_flush_nxt    = 1'b0;
      w_redirect_nxt = 1'b0;
      w_exc_we_nxt   = 1'b0;
      w_epc_we_nxt   = 1'b0;
      w_badv_we_nxt  = 1'b0;
      w_eret_we_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_take_exc || w_take_eret) begin
               w_state_nxt   = S_COMMIT;
               w_stall_nxt   = 1'b1;
               w_flush_nxt   = 1'b1;
               w_exc_we_nxt  = w_take_exc;
               w_epc_we_nxt  = w_take_exc & ~cp0_exl;
               w_badv_we_nxt = w_take_exc & (w_badv_sel != BADV_NONE);
               w_eret_we_nxt = w_take_eret;
            end
         end
         S_COMMIT: begin
            w_state_nxt    = S_REDIRECT;
            w_stall_nxt    = 1'b1;
            w_redirect_nxt = 1'b1;
         end
         S_REDIRECT: begin
            if (fetch_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_stall_nxt    = 1'b1;
               w_redirect_nxt = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and control output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_stall    <= 1'b0;
         r_flush    <= 1'b0;
         r_redirect <= 1'b0;
         r_exc_we   <= 1'b0;
         r_epc_we   <= 1'b0;
         r_badv_we  <= 1'b0;
         r_eret_we  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_stall    <= w_stall_nxt;
         r_flush    <= w_flush_nxt;
         r_redirect <= w_redirect_nxt;
         r_exc_we   <= w_exc_we_nxt;
         r_epc_we   <= w_epc_we_nxt;
         r_badv_we  <= w_badv_we_nxt;
         r_eret_we  <= w_eret_we_nxt;
      end
   end

   // Event data captured when leaving IDLE, held until the next event
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_code   <= '0;
         r_epc    <= '0;
         r_bd     <= 1'b0;
         r_badv   <= '0;
         r_target <= '0;
      end else if (w_latch) begin
         r_code   <= w_take_exc ? w_exc_code : CODE_INT;
         r_epc    <= ex_in_ds ? (ex_pc - PC_W'(4)) : ex_pc;
         r_bd     <= ex_in_ds;
         r_target <= w_take_exc ? EXC_VECTOR : cp0_epc;
         if (w_take_exc && (w_badv_sel == BADV_PC)) begin
            r_badv <= ex_pc;
         end else if (w_take_exc && (w_badv_sel == BADV_DADDR)) begin
            r_badv <= ex_daddr;
         end
      end
   end

   assign stall       = r_stall;
   assign flush       = r_flush;
   assign redirect    = r_redirect;
   assign redirect_pc = r_target;
   assign cp0_exc_we  = r_exc_we;
   assign cp0_exccode = r_code;
   assign cp0_epc_we  = r_epc_we;
   assign cp0_epc_o   = r_epc;
   assign cp0_bd      = r_bd;
   assign cp0_badv_we = r_badv_we;
   assign cp0_badv    = r_badv;
   assign cp0_eret_we = r_eret_we;

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed cases plus random events vs a behavioural model.
module tb_exc_sequencer;

   localparam int unsigned PC_W = 32;
   localparam logic [31:0] VEC  = 32'hBFC00380;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            ex_valid = 1'b0;
   logic [31:0]     ex_pc = '0;
   logic            ex_in_ds = 1'b0;
   logic [7:0]      ex_exc = '0;
   logic            ex_eret = 1'b0;
   logic [31:0]     ex_daddr = '0;
   logic            int_pending = 1'b0;
   logic            cp0_exl = 1'b0;
   logic [31:0]     cp0_epc = '0;
   logic            fetch_ready = 1'b0;
   logic            stall, flush, redirect;
   logic [31:0]     redirect_pc;
   logic            cp0_exc_we, cp0_epc_we, cp0_bd, cp0_badv_we, cp0_eret_we;
   logic [4:0]      cp0_exccode;
   logic [31:0]     cp0_epc_o, cp0_badv;

   int n_checks = 0;
   int n_fail   = 0;

   exc_sequencer #(.PC_W(PC_W), .EXC_VECTOR(VEC)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_in_ds(ex_in_ds),
      .ex_exc(ex_exc), .ex_eret(ex_eret), .ex_daddr(ex_daddr), .int_pending(int_pending),
      .cp0_exl(cp0_exl), .cp0_epc(cp0_epc), .fetch_ready(fetch_ready),
      .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
      .cp0_exc_we(cp0_exc_we), .cp0_exccode(cp0_exccode), .cp0_epc_we(cp0_epc_we),
      .cp0_epc_o(cp0_epc_o), .cp0_bd(cp0_bd), .cp0_badv_we(cp0_badv_we),
      .cp0_badv(cp0_badv), .cp0_eret_we(cp0_eret_we)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Control outputs packed {stall,flush,redirect,exc_we,epc_we,badv_we,eret_we}
   function automatic logic [31:0] ctl();
      return 32'({stall, flush, redirect, cp0_exc_we, cp0_epc_we, cp0_badv_we, cp0_eret_we});
   endfunction

   // ExcCode for each flag position, position order = priority order
   function automatic logic [4:0] code_of(input int i);
      case (i)
         0: return 5'd0;   1: return 5'd4;   2: return 5'd10;  3: return 5'd12;
         4: return 5'd8;   5: return 5'd9;   6: return 5'd4;   default: return 5'd5;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex_valid = 1'b0; ex_exc = '0; ex_eret = 1'b0; int_pending = 1'b0; fetch_ready = 1'b0;
   endtask

   // Random noise on inputs that must be ignored outside IDLE
   task automatic garbage();
      ex_valid = 1'($urandom); ex_pc = $urandom; ex_exc = 8'($urandom); ex_eret = 1'($urandom);
      ex_daddr = $urandom; int_pending = 1'($urandom); cp0_exl = 1'($urandom);
      cp0_epc = $urandom; ex_in_ds = 1'($urandom);
   endtask

   // Present one committing instruction in IDLE and follow the full sequence
   task automatic evt(input logic v, input logic [31:0] pc, input logic ds, input logic [7:0] exc,
                      input logic er, input logic [31:0] da, input logic ip, input logic exl,
                      input logic [31:0] epc_in, input int delay);
      logic [7:0]  f;
      int          first;
      bit          tx, te, bh;
      logic [31:0] tgt, bv, epc_exp;
      f = exc;
      f[0] = f[0] | ip;
      first = -1;
      for (int i = 0; i < 8; i++) if (f[i] && first < 0) first = i;
      tx = v && (first >= 0);
      te = v && er && !tx;
      bh = tx && (first == 1 || first == 6 || first == 7);
      bv = (first == 1) ? pc : da;
      tgt = tx ? VEC : epc_in;
      epc_exp = ds ? pc - 32'd4 : pc;
      ex_valid = v; ex_pc = pc; ex_in_ds = ds; ex_exc = exc; ex_eret = er; ex_daddr = da;
      int_pending = ip; cp0_exl = exl; cp0_epc = epc_in; fetch_ready = 1'($urandom);
      step();
      if (!tx && !te) begin
         check("idle_ctl", ctl(), 32'd0);
         idle_inputs();
         return;
      end
      check("commit_ctl", ctl(), 32'({1'b1, 1'b1, 1'b0, tx, tx && !exl, bh, te}));
      if (tx) begin
         check("commit_code", 32'(cp0_exccode), 32'(code_of(first)));
         check("commit_epc", cp0_epc_o, epc_exp);
         check("commit_bd", 32'(cp0_bd), 32'(ds));
         if (bh) check("commit_badv", cp0_badv, bv);
      end
      garbage();
      fetch_ready = 1'($urandom);
      for (int k = 0; k <= delay; k++) begin
         step();
         check("redir_ctl", ctl(), 32'b1010000);
         check("redir_pc", redirect_pc, tgt);
         if (k == delay) begin
            idle_inputs();
            fetch_ready = 1'b1;
         end else begin
            garbage();
            fetch_ready = 1'b0;
         end
      end
      step();
      check("post_ctl", ctl(), 32'd0);
      fetch_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_ctl", ctl(), 32'd0);
      check("rst_pc", redirect_pc, 32'd0);
      check("rst_code", 32'(cp0_exccode), 32'd0);
      step();
      rst = 1'b1;
      step();

      // 1: OV, not in delay slot
      evt(1, 32'h80001000, 0, 8'h08, 0, 32'h0, 0, 0, 32'h0, 0);
      // 2: ADES in delay slot
      evt(1, 32'h80002004, 1, 8'h80, 0, 32'h00000013, 0, 0, 32'h0, 0);
      // 3: RI+SYS+ADEL with and without pending interrupt
      evt(1, 32'h80004000, 0, 8'h54, 0, 32'h1234, 1, 0, 32'h0, 1);
      evt(1, 32'h80004000, 0, 8'h54, 0, 32'h1234, 0, 0, 32'h0, 0);
      // 4: ERET with fetch stalled three cycles
      evt(1, 32'h80005000, 0, 8'h00, 1, 32'h0, 0, 1, 32'h80003000, 3);
      // 5: SYS while EXL set; ERET together with BP
      evt(1, 32'h80006000, 0, 8'h10, 0, 32'h0, 0, 1, 32'h0, 0);
      evt(1, 32'h80007000, 0, 8'h20, 1, 32'h0, 0, 0, 32'h80003000, 2);
      // Invalid instruction with flags is ignored
      evt(0, 32'h80008000, 0, 8'hFF, 1, 32'h0, 1, 0, 32'h0, 0);
      // ADEL_IF captures the PC as BadVAddr
      evt(1, 32'h80009001, 1, 8'h02, 0, 32'hDEAD0000, 0, 0, 32'h0, 1);

      // 6: reset while redirect is pending
      ex_valid = 1; ex_exc = 8'h08; ex_pc = 32'h8000A000; cp0_exl = 0; fetch_ready = 0;
      step();
      idle_inputs();
      step();
      check("pre_rst_ctl", ctl(), 32'b1010000);
      #2 rst = 1'b0;
      #1;
      check("midrst_ctl", ctl(), 32'd0);
      check("midrst_pc", redirect_pc, 32'd0);
      check("midrst_code", 32'(cp0_exccode), 32'd0);
      step();
      rst = 1'b1;
      fetch_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("after_rst_ctl", ctl(), 32'd0);
      end
      fetch_ready = 1'b0;

      // Random events
      for (int n = 0; n < 300; n++) begin
         logic [7:0] e;
         e = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         evt(($urandom_range(0, 7) != 0), $urandom, 1'($urandom), e, 1'($urandom), $urandom,
             ($urandom_range(0, 3) == 0), 1'($urandom), $urandom, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
